// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Segment bit positions and active-high glyph codes shared by
//               the seven-segment scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int c_SEG_A  = 0;
    localparam int c_SEG_B  = 1;
    localparam int c_SEG_C  = 2;
    localparam int c_SEG_D  = 3;
    localparam int c_SEG_E  = 4;
    localparam int c_SEG_F  = 5;
    localparam int c_SEG_G  = 6;
    localparam int c_SEG_DP = 7;

    // Bit order g,f,e,d,c,b,a with a lit segment reading as 1.
    localparam logic [6:0] c_GLYPH_0 = 7'h3F;
    localparam logic [6:0] c_GLYPH_1 = 7'h06;
    localparam logic [6:0] c_GLYPH_2 = 7'h5B;
    localparam logic [6:0] c_GLYPH_3 = 7'h4F;
    localparam logic [6:0] c_GLYPH_4 = 7'h66;
    localparam logic [6:0] c_GLYPH_5 = 7'h6D;
    localparam logic [6:0] c_GLYPH_6 = 7'h7D;
    localparam logic [6:0] c_GLYPH_7 = 7'h07;
    localparam logic [6:0] c_GLYPH_8 = 7'h7F;
    localparam logic [6:0] c_GLYPH_9 = 7'h6F;
    localparam logic [6:0] c_GLYPH_A = 7'h77;
    localparam logic [6:0] c_GLYPH_B = 7'h7C;
    localparam logic [6:0] c_GLYPH_C = 7'h39;
    localparam logic [6:0] c_GLYPH_D = 7'h5E;
    localparam logic [6:0] c_GLYPH_E = 7'h79;
    localparam logic [6:0] c_GLYPH_F = 7'h71;

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Scan-side inputs and published-frame outputs of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 8
);
    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic                    sample_en;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic [NUM_DIGITS-1:0]   invalid_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;

    modport master (
        output seg_in, an_in, sample_en, out_ready,
        input  hex_out, dp_out, invalid_out, out_valid, overrun
    );

    modport slave (
        input  seg_in, an_in, sample_en, out_ready,
        output hex_out, dp_out, invalid_out, out_valid, overrun
    );
endinterface
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_decode
// Description : Active-high 7-segment pattern to hex nibble, flagging
//               patterns that are not one of the sixteen hex glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
    import seg_pkg::*;
(
    input  wire logic [6:0] i_pattern,
    output logic      [3:0] o_nibble,
    output logic            o_invalid
);

    always_comb begin
        o_nibble  = 4'h0;
        o_invalid = 1'b0;
        case (i_pattern)
            c_GLYPH_0: o_nibble = 4'h0;
            c_GLYPH_1: o_nibble = 4'h1;
            c_GLYPH_2: o_nibble = 4'h2;
            c_GLYPH_3: o_nibble = 4'h3;
            c_GLYPH_4: o_nibble = 4'h4;
            c_GLYPH_5: o_nibble = 4'h5;
            c_GLYPH_6: o_nibble = 4'h6;
            c_GLYPH_7: o_nibble = 4'h7;
            c_GLYPH_8: o_nibble = 4'h8;
            c_GLYPH_9: o_nibble = 4'h9;
            c_GLYPH_A: o_nibble = 4'hA;
            c_GLYPH_B: o_nibble = 4'hB;
            c_GLYPH_C: o_nibble = 4'hC;
            c_GLYPH_D: o_nibble = 4'hD;
            c_GLYPH_E: o_nibble = 4'hE;
            c_GLYPH_F: o_nibble = 4'hF;
            default:   o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Reconstructs hex digits from a multiplexed 7-segment scan and
//               publishes a frame once it has been stable for several scans.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int STABLE_FRAMES  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seg_scan_decoder_if.slave bus
);

    localparam int                   c_CNT_W  = 4;
    localparam logic [c_CNT_W-1:0]   c_STABLE = c_CNT_W'(STABLE_FRAMES);
    localparam logic [NUM_DIGITS-1:0] c_ONE   = NUM_DIGITS'(1);

    logic [7:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;
    logic                    w_one_hot;
    logic                    w_capture;
    logic [NUM_DIGITS-1:0]   w_hit;
    logic [3:0]              w_nib;
    logic                    w_inv;
    logic                    w_dp;
    logic [4*NUM_DIGITS-1:0] w_cand_hex;
    logic [NUM_DIGITS-1:0]   w_cand_dp;
    logic [NUM_DIGITS-1:0]   w_cand_inv;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_complete;
    logic                    w_same;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic                    w_publish;

    logic [4*NUM_DIGITS-1:0] r_sh_hex;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_inv;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [4*NUM_DIGITS-1:0] r_last_hex;
    logic [NUM_DIGITS-1:0]   r_last_dp;
    logic [NUM_DIGITS-1:0]   r_last_inv;
    logic [4*NUM_DIGITS-1:0] r_hex_out;
    logic [NUM_DIGITS-1:0]   r_dp_out;
    logic [NUM_DIGITS-1:0]   r_inv_out;
    logic                    r_out_valid;
    logic                    r_overrun;

    assign w_seg = (SEG_ACTIVE_LOW != 0) ? ~bus.seg_in : bus.seg_in;
    assign w_an  = (AN_ACTIVE_LOW  != 0) ? ~bus.an_in  : bus.an_in;

    // Exactly one anode: non-zero with no second bit set.
    assign w_one_hot = (w_an != '0) && ((w_an & (w_an - c_ONE)) == '0);
    assign w_capture = bus.sample_en && w_one_hot;
    assign w_hit     = w_capture ? w_an : '0;
    assign w_dp      = w_seg[c_SEG_DP];

    seg_glyph_decode u_glyph (
        .i_pattern (w_seg[c_SEG_G:c_SEG_A]),
        .o_nibble  (w_nib),
        .o_invalid (w_inv)
    );

    // Shadow contents with the current sample merged in.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        assign w_cand_hex[4*gi +: 4] = w_hit[gi] ? w_nib : r_sh_hex[4*gi +: 4];
        assign w_cand_dp[gi]         = w_hit[gi] ? w_dp  : r_sh_dp[gi];
        assign w_cand_inv[gi]        = w_hit[gi] ? w_inv : r_sh_inv[gi];
    end

    assign w_seen_next = r_seen | w_hit;
    assign w_complete  = w_capture && (&w_seen_next);

    // A zero match count means no candidate has been seen since reset.
    assign w_same = (r_cnt != '0) &&
                    ({w_cand_hex, w_cand_dp, w_cand_inv} ==
                     {r_last_hex, r_last_dp, r_last_inv});

    assign w_cnt_next = !w_same            ? c_CNT_W'(1) :
                        (r_cnt == c_STABLE) ? r_cnt       :
                                              r_cnt + c_CNT_W'(1);

    assign w_publish = w_complete && (w_cnt_next == c_STABLE) &&
                       ((r_cnt != c_STABLE) || !w_same);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_hex    <= '0;
            r_sh_dp     <= '0;
            r_sh_inv    <= '0;
            r_seen      <= '0;
            r_cnt       <= '0;
            r_last_hex  <= '0;
            r_last_dp   <= '0;
            r_last_inv  <= '0;
            r_hex_out   <= '0;
            r_dp_out    <= '0;
            r_inv_out   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sh_hex <= w_cand_hex;
                r_sh_dp  <= w_cand_dp;
                r_sh_inv <= w_cand_inv;
                r_seen   <= w_complete ? '0 : w_seen_next;
            end
            if (w_complete) begin
                r_cnt      <= w_cnt_next;
                r_last_hex <= w_cand_hex;
                r_last_dp  <= w_cand_dp;
                r_last_inv <= w_cand_inv;
            end
            if (w_publish) begin
                r_hex_out   <= w_cand_hex;
                r_dp_out    <= w_cand_dp;
                r_inv_out   <= w_cand_inv;
                r_out_valid <= 1'b1;
                if (r_out_valid && !bus.out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.hex_out     = r_hex_out;
    assign bus.dp_out      = r_dp_out;
    assign bus.invalid_out = r_inv_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Scoreboard bench for seg_scan_decoder with default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int STABLE = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   acc_cnt;
    bit   mon_on;

    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state; a frame is {hex[31:0], dp[7:0], inv[7:0]}.
    logic [31:0] m_sh_hex;
    logic [7:0]  m_sh_dp;
    logic [7:0]  m_sh_inv;
    logic [7:0]  m_seen;
    logic [47:0] m_last;
    bit          m_have_last;
    int          m_cnt;
    bit          m_valid;
    bit          m_overrun;
    logic [47:0] sb_q [$];

    seg_scan_decoder_if #(.NUM_DIGITS(8)) bus_if ();

    seg_scan_decoder #(
        .NUM_DIGITS     (8),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1),
        .STABLE_FRAMES  (STABLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tb_decode(input logic [6:0] p, output logic [3:0] n, output logic inv);
        n   = 4'h0;
        inv = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (glyph_tab[k] == p) begin
                n   = k[3:0];
                inv = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_sh_hex    = '0;
        m_sh_dp     = '0;
        m_sh_inv    = '0;
        m_seen      = '0;
        m_last      = '0;
        m_have_last = 0;
        m_cnt       = 0;
        m_valid     = 0;
        m_overrun   = 0;
        sb_q.delete();
    endtask

    task automatic model_step();
        logic [7:0]  an_n;
        logic [7:0]  seg_n;
        logic [3:0]  nib;
        logic        inv;
        logic [47:0] cand;
        int          d;
        int          ones;
        int          old;
        bit          same;
        bit          pub;
        pub  = 0;
        cand = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (bus_if.sample_en) begin
            an_n  = ~bus_if.an_in;
            seg_n = ~bus_if.seg_in;
            ones  = 0;
            d     = 0;
            for (int k = 0; k < 8; k++) begin
                if (an_n[k]) begin
                    ones++;
                    d = k;
                end
            end
            if (ones == 1) begin
                tb_decode(seg_n[6:0], nib, inv);
                m_sh_hex[4*d +: 4] = nib;
                m_sh_dp[d]         = seg_n[7];
                m_sh_inv[d]        = inv;
                m_seen[d]          = 1'b1;
                if (m_seen == 8'hFF) begin
                    cand = {m_sh_hex, m_sh_dp, m_sh_inv};
                    same = m_have_last && (cand == m_last);
                    old  = m_cnt;
                    if (!same)             m_cnt = 1;
                    else if (m_cnt < STABLE) m_cnt = m_cnt + 1;
                    pub         = (m_cnt == STABLE) && ((old != STABLE) || !same);
                    m_last      = cand;
                    m_have_last = 1;
                    m_seen      = '0;
                end
            end
        end
        if (pub) begin
            if (m_valid && !bus_if.out_ready && sb_q.size() > 0) begin
                sb_q[sb_q.size()-1] = cand;
                m_overrun = 1;
            end else begin
                sb_q.push_back(cand);
            end
            m_valid = 1;
        end else if (m_valid && bus_if.out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic monitor_step();
        logic [47:0] exp;
        check("out_valid", bus_if.out_valid, m_valid);
        check("overrun", bus_if.overrun, m_overrun);
        if (bus_if.out_valid && bus_if.out_ready) begin
            acc_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", bus_if.out_valid, 1'b0);
            end else begin
                exp = sb_q.pop_front();
                check("sb_hex", bus_if.hex_out, exp[47:16]);
                check("sb_dp", bus_if.dp_out, exp[15:8]);
                check("sb_inv", bus_if.invalid_out, exp[7:0]);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) monitor_step();
    end

    function automatic logic [7:0] seg_of(input int n, input logic dp);
        logic [6:0] g;
        g = glyph_tab[n];
        return ~{dp, g};
    endfunction

    task automatic sample(input logic [7:0] seg, input logic [7:0] an);
        bus_if.seg_in    = seg;
        bus_if.an_in     = an;
        bus_if.sample_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.sample_en = 1'b0;
        bus_if.an_in     = 8'hFF;
    endtask

    task automatic frame_raw(input logic [63:0] segs);
        for (int d = 7; d >= 0; d--) sample(segs[8*d +: 8], ~(8'h01 << d));
    endtask

    task automatic frame(input logic [31:0] hex, input logic [7:0] dp);
        logic [63:0] segs;
        for (int d = 0; d < 8; d++) segs[8*d +: 8] = seg_of(int'(hex[4*d +: 4]), dp[d]);
        frame_raw(segs);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [63:0] segs;
        int          acc_before;
        n_checks = 0;
        n_errors = 0;
        acc_cnt  = 0;
        mon_on   = 0;
        model_reset();
        rst              = 1'b1;
        bus_if.seg_in    = 8'hFF;
        bus_if.an_in     = 8'hFF;
        bus_if.sample_en = 1'b0;
        bus_if.out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_valid", bus_if.out_valid, 1'b0);
        check("rst_hex", bus_if.hex_out, 32'h0);
        check("rst_dp", bus_if.dp_out, 8'h0);
        check("rst_inv", bus_if.invalid_out, 8'h0);
        check("rst_overrun", bus_if.overrun, 1'b0);
        mon_on = 1;

        // Two identical scans publish one cycle after the last sample.
        frame(32'h12345678, 8'h00);
        check("f1_no_pub", bus_if.out_valid, 1'b0);
        frame(32'h12345678, 8'h00);
        check("lat_valid", bus_if.out_valid, 1'b1);
        check("lat_hex", bus_if.hex_out, 32'h12345678);
        check("lat_dp", bus_if.dp_out, 8'h00);
        check("lat_inv", bus_if.invalid_out, 8'h00);
        idle(3);

        // Blank digit 3 is invalid; digit 5 shows 0 with its decimal point.
        for (int d = 0; d < 8; d++) segs[8*d +: 8] = 8'hC0;
        segs[8*3 +: 8] = 8'hFF;
        segs[8*5 +: 8] = 8'h40;
        frame_raw(segs);
        frame_raw(segs);
        check("inv_flags", bus_if.invalid_out, 8'h08);
        check("inv_hex", bus_if.hex_out, 32'h0);
        check("dp_flags", bus_if.dp_out, 8'h20);
        idle(3);

        // Dual-anode sample must neither store nor complete the frame.
        for (int it = 0; it < 2; it++) begin
            for (int d = 7; d >= 2; d--) sample(seg_of(int'(32'hCAFE0123 >> (4*d)) & 15, 1'b0), ~(8'h01 << d));
            sample(8'h00, 8'hFC);
            check("dual_no_pub", bus_if.out_valid, 1'b0);
            sample(seg_of(3, 1'b0), 8'hFE);
            check("d0_no_pub", bus_if.out_valid, 1'b0);
            sample(seg_of(2, 1'b0), 8'hFD);
            check("d1_pub", bus_if.out_valid, it == 1);
        end
        check("dual_hex", bus_if.hex_out, 32'hCAFE0123);
        check("dual_dp", bus_if.dp_out, 8'h00);
        idle(3);

        // A, B, B, B publishes B exactly once.
        acc_before = acc_cnt;
        frame(32'h9ABCDEF0, 8'h00);
        check("a_no_pub", bus_if.out_valid, 1'b0);
        frame(32'h0F1E2D3C, 8'h00);
        frame(32'h0F1E2D3C, 8'h00);
        check("b2_pub", bus_if.out_valid, 1'b1);
        idle(2);
        frame(32'h0F1E2D3C, 8'h00);
        check("b3_no_pub", bus_if.out_valid, 1'b0);
        idle(2);
        check("pub_count", acc_cnt - acc_before, 1);
        check("hold_hex", bus_if.hex_out, 32'h0F1E2D3C);

        // Two publishes with no acceptance in between.
        bus_if.out_ready = 1'b0;
        frame(32'hC0C0C0C0, 8'h11);
        frame(32'hC0C0C0C0, 8'h11);
        check("c_pub", bus_if.out_valid, 1'b1);
        check("c_no_ovr", bus_if.overrun, 1'b0);
        frame(32'hD0D0D0D0, 8'h00);
        frame(32'hD0D0D0D0, 8'h00);
        check("d_valid", bus_if.out_valid, 1'b1);
        check("d_hex", bus_if.hex_out, 32'hD0D0D0D0);
        check("d_overrun", bus_if.overrun, 1'b1);
        bus_if.out_ready = 1'b1;
        idle(1);
        bus_if.out_ready = 1'b0;
        check("acc_valid", bus_if.out_valid, 1'b0);
        check("ovr_sticky", bus_if.overrun, 1'b1);
        bus_if.out_ready = 1'b1;
        idle(2);

        // Partial frame discarded by reset; sample during reset ignored.
        for (int d = 0; d < 5; d++) sample(seg_of(d + 1, 1'b0), ~(8'h01 << d));
        rst              = 1'b1;
        bus_if.seg_in    = seg_of(7, 1'b1);
        bus_if.an_in     = ~(8'h01 << 5);
        bus_if.sample_en = 1'b1;
        idle(1);
        rst              = 1'b0;
        bus_if.sample_en = 1'b0;
        bus_if.an_in     = 8'hFF;
        check("post_rst_ovr", bus_if.overrun, 1'b0);
        for (int d = 0; d < 8; d++) segs[8*d +: 8] = 8'hA5;
        frame_raw(segs);
        check("a5_f1_no_pub", bus_if.out_valid, 1'b0);
        frame_raw(segs);
        check("a5_valid", bus_if.out_valid, 1'b1);
        check("a5_hex", bus_if.hex_out, 32'h0);
        check("a5_inv", bus_if.invalid_out, 8'hFF);
        check("a5_dp", bus_if.dp_out, 8'h00);
        idle(4);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, range 1..16.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 means a segment is lit when its seg_in bit is 0.
REQ-003 Parameter AN_ACTIVE_LOW, default 1: 1 means a digit is selected when its an_in bit is 0.
REQ-004 Parameter STABLE_FRAMES, default 2: identical consecutive frames required before publishing, range 1..15.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 seg_in  input  8  segment pattern: bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
REQ-008 an_in  input  NUM_DIGITS  anode selects; bit i selects digit i.
REQ-009 sample_en  input  1  strobe; seg_in/an_in are sampled only in cycles where it is high.
REQ-010 hex_out  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits 4i+3..4i.
REQ-011 dp_out  output  NUM_DIGITS  decimal-point lit flags per digit.
REQ-012 invalid_out  output  NUM_DIGITS  per-digit flag: pattern did not match any glyph.
REQ-013 out_valid  output  1  published frame available.
REQ-014 out_ready  input  1  consumer accepts the published frame.
REQ-015 overrun  output  1  sticky: a published frame was overwritten before acceptance.

Function
REQ-016 seg_in and an_in SHALL be normalised to active-high using the polarity parameters before any other processing.
REQ-017 Glyph decode SHALL use bits6..0 only and map the 16 glyphs 0-9, A, b, C, d, E, F to 0x0..0xF (active-low codes for 0 and F: 7'h40 and 7'h0E); dp SHALL be reported separately.
REQ-018 An unmatched 7-bit pattern SHALL decode to nibble 0 with the invalid flag set.
REQ-019 On a sample_en cycle with exactly one normalised anode active (digit i), the decoder SHALL store nibble, dp and invalid flag into shadow slot i and set seen[i].
REQ-020 A sample_en cycle with zero or several active anodes SHALL be ignored, with no state change.
REQ-021 Resampling an already-seen digit SHALL overwrite its shadow slot.
REQ-022 When all seen bits are set (counting the current sample), the shadow contents SHALL form the candidate frame, and seen SHALL clear in that same edge.
REQ-023 Candidate vs last candidate (all hex, dp and invalid bits):
- equal: match_cnt increments, saturating at STABLE_FRAMES;
- different, or first frame after reset: match_cnt = 1.
- The last candidate is then updated.
REQ-024 A publish SHALL occur when the new match_cnt equals STABLE_FRAMES and either the old match_cnt differed from STABLE_FRAMES or the frame mismatched.
- Consequence: a stable display publishes once, not every frame.
REQ-025 On publish, hex_out, dp_out and invalid_out SHALL load at the edge ending the completing sample cycle, with out_valid high from that edge (latency 1 cycle).
REQ-026 out_valid SHALL remain high until a cycle with out_ready high, then clear at the next edge; outputs SHALL hold their value when not publishing.
REQ-027 A publish while out_valid=1 and out_ready=0 SHALL overwrite the outputs, keep out_valid high and set overrun.
REQ-028 A publish in the same cycle as an acceptance SHALL load the new data with out_valid staying high, and SHALL NOT set overrun.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 While rst is high, all of the following SHALL be 0 at the next edge: hex_out, dp_out, invalid_out, out_valid, overrun, seen, shadow slots, match_cnt and last candidate.
REQ-031 A partially captured frame SHALL be discarded by reset, and sample_en SHALL be ignored in the reset cycle.

Structure
REQ-032 Package seg_pkg SHALL hold the 16 active-high 7-bit glyph constants and the segment bit-index constants for dp and a..g.
REQ-033 Sub-module seg_glyph_decode (combinational: 7-bit pattern -> nibble plus invalid) SHALL be instantiated once on the normalised sampled pattern.

Verification
REQ-034 Defaults; scan digits 7..0 showing 1,2,3,4,5,6,7,8 as two full frames with dp off -> one out_valid one cycle after the 16th sample; hex_out=32'h12345678, dp_out=0, invalid_out=0.
REQ-035 Digit 3 driven with seg_in=8'hFF for two frames, other digits '0' -> invalid_out=8'h08, hex_out nibble 3=0; digit 5 with seg_in=8'h40 (0 plus dp) -> dp_out[5]=1.
REQ-036 Sample with an_in=8'hFC (two anodes), then digits 0 and 1 singly with digits 2..7 already seen -> frame completes only on the digit-1 sample; the dual-anode sample has no effect.
REQ-037 Frames A, B, B, B with STABLE_FRAMES=2 -> exactly one publish, after the 2nd B, carrying B; no publish after A or the 3rd B.
REQ-038 out_ready=0 across two publishes (frames C then D) -> out_valid stays 1, hex_out=D, overrun=1; then out_ready=1 for one cycle -> out_valid=0 next cycle, overrun stays 1.
REQ-039 Five digits captured, rst high one cycle, then two full frames of 8'hA5-pattern digits -> published data reflects only post-reset samples; an early publish after 3 digits is a failure.
